// File: rtl/arm_multiplier.sv
// ARM7TDMI multiply unit: MUL/MLA/UMULL/SMULL/UMLAL/SMLAL.
// It retires 8 multiplier bits per ITER cycle and uses early termination on Rs.
module arm_multiplier #(
   parameter logic EARLY_TERM = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        accumulate,
   input  logic        long_op,
   input  logic        signed_op,
   input  logic        set_flags,
   input  logic [3:0]  rd_in,
   input  logic [3:0]  rdhi_in,
   input  logic [31:0] Rm_data,
   input  logic [31:0] Rs_data,
   input  logic [31:0] Rn_data,
   input  logic [31:0] acc_hi,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [3:0]  Rd,
   output logic [3:0]  RdHi,
   output logic [31:0] Rd_data,
   output logic [31:0] RdHi_data,
   output logic        regWrite,
   output logic        regHiWrite,
   output logic        flag_n,
   output logic        flag_z,
   output logic        flags_we
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_ACC, S_HI} state_t;

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  last_q, last_d;
   logic        acc_q, acc_d;
   logic        long_q, long_d;
   logic        setf_q, setf_d;
   logic [3:0]  rd_q, rd_d;
   logic [3:0]  rdhi_q, rdhi_d;
   logic [63:0] mcand_q, mcand_d;
   logic [32:0] mplier_q, mplier_d;
   logic [63:0] addend_q, addend_d;
   logic [63:0] res_q, res_d;
   logic        done_q, done_d;
   logic        hiwe_q, hiwe_d;
   logic        fwe_q, fwe_d;
   logic [3:0]  rd_out_q, rd_out_d;
   logic [3:0]  rdhi_out_q, rdhi_out_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic        n_q, n_d;
   logic        z_q, z_d;

   logic        accept, uns_long, ones_ok, finish;
   logic        z8, z16, z24, o8, o16, o24;
   logic [8:0]  digit;
   logic [63:0] pp, sum;

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      acc_d      = acc_q;
      long_d     = long_q;
      setf_d     = setf_q;
      rd_d       = rd_q;
      rdhi_d     = rdhi_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      addend_d   = addend_q;
      res_d      = res_q;
      done_d     = 1'b0;
      hiwe_d     = 1'b0;
      fwe_d      = 1'b0;
      rd_out_d   = rd_out_q;
      rdhi_out_d = rdhi_out_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      n_d        = n_q;
      z_d        = z_q;
      finish     = 1'b0;

      accept   = start & ~busy_q & ~flush;
      uns_long = long_op & ~signed_op;
      ones_ok  = ~long_op | signed_op;
      z8  = ~|Rs_data[31:8];
      z16 = ~|Rs_data[31:16];
      z24 = ~|Rs_data[31:24];
      o8  = &Rs_data[31:8];
      o16 = &Rs_data[31:16];
      o24 = &Rs_data[31:24];

      // The last digit carries the sign of the bits above it: those bits are
      // either all zeros or all ones, because termination only happens then.
      digit = {(cnt_q == last_q) & mplier_q[8], mplier_q[7:0]};
      pp    = mcand_q * {{55{digit[8]}}, digit};
      case (state_q)
         S_ITER:  sum = res_q + pp;
         S_ACC:   sum = res_q + addend_q;
         default: sum = res_q;
      endcase

      if (flush && busy_q) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               state_d  = S_ITER;
               busy_d   = 1'b1;
               cnt_d    = 2'd0;
               acc_d    = accumulate;
               long_d   = long_op;
               setf_d   = set_flags;
               rd_d     = rd_in;
               rdhi_d   = rdhi_in;
               mcand_d  = {{32{Rm_data[31] & ~uns_long}}, Rm_data};
               mplier_d = {Rs_data[31] & ~uns_long, Rs_data};
               addend_d = {long_op ? acc_hi : 32'd0, Rn_data};
               res_d    = 64'd0;
               if (!EARLY_TERM)                 last_d = 2'd3;
               else if (z8  || (o8  && ones_ok)) last_d = 2'd0;
               else if (z16 || (o16 && ones_ok)) last_d = 2'd1;
               else if (z24 || (o24 && ones_ok)) last_d = 2'd2;
               else                              last_d = 2'd3;
            end
            S_ITER: begin
               res_d    = sum;
               mcand_d  = {mcand_q[55:0], 8'd0};
               mplier_d = {{8{mplier_q[32]}}, mplier_q[32:8]};
               cnt_d    = cnt_q + 2'd1;
               if (cnt_q == last_q) begin
                  if (acc_q)       state_d = S_ACC;
                  else if (long_q) state_d = S_HI;
                  else             finish  = 1'b1;
               end
            end
            S_ACC: begin
               res_d = sum;
               if (long_q) state_d = S_HI;
               else        finish  = 1'b1;
            end
            S_HI:    finish = 1'b1;
            default: state_d = S_IDLE;
         endcase

         if (finish) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            hiwe_d     = long_q;
            fwe_d      = setf_q;
            rd_out_d   = rd_q;
            rdhi_out_d = rdhi_q;
            lo_d       = sum[31:0];
            hi_d       = long_q ? sum[63:32] : 32'd0;
            n_d        = long_q ? sum[63] : sum[31];
            z_d        = long_q ? (sum == 64'd0) : (sum[31:0] == 32'd0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         cnt_q      <= 2'd0;
         last_q     <= 2'd0;
         acc_q      <= 1'b0;
         long_q     <= 1'b0;
         setf_q     <= 1'b0;
         rd_q       <= 4'd0;
         rdhi_q     <= 4'd0;
         mcand_q    <= 64'd0;
         mplier_q   <= 33'd0;
         addend_q   <= 64'd0;
         res_q      <= 64'd0;
         done_q     <= 1'b0;
         hiwe_q     <= 1'b0;
         fwe_q      <= 1'b0;
         rd_out_q   <= 4'd0;
         rdhi_out_q <= 4'd0;
         lo_q       <= 32'd0;
         hi_q       <= 32'd0;
         n_q        <= 1'b0;
         z_q        <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         acc_q      <= acc_d;
         long_q     <= long_d;
         setf_q     <= setf_d;
         rd_q       <= rd_d;
         rdhi_q     <= rdhi_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         addend_q   <= addend_d;
         res_q      <= res_d;
         done_q     <= done_d;
         hiwe_q     <= hiwe_d;
         fwe_q      <= fwe_d;
         rd_out_q   <= rd_out_d;
         rdhi_out_q <= rdhi_out_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         n_q        <= n_d;
         z_q        <= z_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign regWrite   = done_q;
   assign regHiWrite = hiwe_q;
   assign flags_we   = fwe_q;
   assign Rd         = rd_out_q;
   assign RdHi       = rdhi_out_q;
   assign Rd_data    = lo_q;
   assign RdHi_data  = hi_q;
   assign flag_n     = n_q;
   assign flag_z     = z_q;

endmodule

// File: tb/tb_arm_multiplier.sv
// Directed bench for arm_multiplier: a scoreboard of reference results and latencies,
// checked on each done pulse.
module tb_arm_multiplier;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start = 1'b0, accumulate = 1'b0, long_op = 1'b0, signed_op = 1'b0;
   logic        set_flags = 1'b0, flush = 1'b0;
   logic [3:0]  rd_in = 4'd0, rdhi_in = 4'd0;
   logic [31:0] Rm_data = 32'd0, Rs_data = 32'd0, Rn_data = 32'd0, acc_hi = 32'd0;
   logic        busy, done, regWrite, regHiWrite, flag_n, flag_z, flags_we;
   logic [3:0]  Rd, RdHi;
   logic [31:0] Rd_data, RdHi_data;

   always #5 clk = ~clk;

   arm_multiplier dut (
      .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
      .long_op(long_op), .signed_op(signed_op), .set_flags(set_flags),
      .rd_in(rd_in), .rdhi_in(rdhi_in), .Rm_data(Rm_data), .Rs_data(Rs_data),
      .Rn_data(Rn_data), .acc_hi(acc_hi), .flush(flush), .busy(busy), .done(done),
      .Rd(Rd), .RdHi(RdHi), .Rd_data(Rd_data), .RdHi_data(RdHi_data),
      .regWrite(regWrite), .regHiWrite(regHiWrite), .flag_n(flag_n),
      .flag_z(flag_z), .flags_we(flags_we)
   );

   typedef struct {
      logic [31:0] lo, hi;
      logic [3:0]  rd, rdhi;
      logic        hiwe, fwe, n, z;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic acc, lng, sgn, setf, input logic [3:0] rd, rdhi,
                                  input logic [31:0] rm, rs, rn, ah);
      exp_t e;
      logic [63:0] a, b, p;
      logic ones_ok;
      int m;
      if (lng && sgn) begin
         a = {{32{rm[31]}}, rm};
         b = {{32{rs[31]}}, rs};
      end else begin
         a = {32'd0, rm};
         b = {32'd0, rs};
      end
      p = a * b;
      if (acc) p = p + (lng ? {ah, rn} : {32'd0, rn});
      ones_ok = !lng || sgn;
      if (rs[31:8] == 24'd0 || (ones_ok && rs[31:8] == {24{1'b1}}))        m = 1;
      else if (rs[31:16] == 16'd0 || (ones_ok && rs[31:16] == {16{1'b1}})) m = 2;
      else if (rs[31:24] == 8'd0 || (ones_ok && rs[31:24] == {8{1'b1}}))   m = 3;
      else                                                                  m = 4;
      e.lat  = m + (acc ? 1 : 0) + (lng ? 1 : 0);
      e.rd   = rd;
      e.rdhi = rdhi;
      e.hiwe = lng;
      e.fwe  = setf;
      e.lo   = p[31:0];
      e.hi   = lng ? p[63:32] : 32'd0;
      e.n    = lng ? p[63] : p[31];
      e.z    = lng ? (p == 64'd0) : (p[31:0] == 32'd0);
      return e;
   endfunction

   task automatic issue(input logic acc, lng, sgn, setf, input logic [3:0] rd, rdhi,
                        input logic [31:0] rm, rs, rn, ah);
      accumulate = acc; long_op = lng; signed_op = sgn; set_flags = setf;
      rd_in = rd; rdhi_in = rdhi; Rm_data = rm; Rs_data = rs; Rn_data = rn; acc_hi = ah;
      sb.push_back(model(acc, lng, sgn, setf, rd, rdhi, rm, rs, rn, ah));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0);
      exp_t e;
      int cyc;
      e = sb.pop_front();
      cyc = cyc0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (done !== 1'b1 && cyc < 30);
      chk("done_seen", 64'(done), 64'd1);
      chk("latency", 64'(cyc), 64'(e.lat));
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("regWrite", 64'(regWrite), 64'd1);
      chk("regHiWrite", 64'(regHiWrite), 64'(e.hiwe));
      chk("flags_we", 64'(flags_we), 64'(e.fwe));
      chk("Rd_data", 64'(Rd_data), 64'(e.lo));
      chk("RdHi_data", 64'(RdHi_data), 64'(e.hi));
      chk("Rd", 64'(Rd), 64'(e.rd));
      chk("RdHi", 64'(RdHi), 64'(e.rdhi));
      chk("flag_n", 64'(flag_n), 64'(e.n));
      chk("flag_z", 64'(flag_z), 64'(e.z));
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      int cnt = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (done || regWrite || regHiWrite || flags_we) cnt++;
      end
      chk(tag, 64'(cnt), 64'd0);
   endtask

   initial begin
      logic [31:0] r, rs;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_strobes", 64'({regWrite, regHiWrite, flags_we}), 64'd0);
      chk("rst_data", {RdHi_data, Rd_data}, 64'd0);
      chk("rst_flags", 64'({flag_n, flag_z, Rd, RdHi}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // MUL 3*5, then the write strobes drop and the result holds
      issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 32'd3, 32'd5, 32'd0, 32'd0);
      wait_done(0);
      @(posedge clk); #1;
      chk("strobe_drop", 64'({done, regWrite, regHiWrite, flags_we}), 64'd0);
      chk("hold_Rd_data", 64'(Rd_data), 64'd15);

      // MLA
      issue(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 32'h0001_0000, 32'h0001_0000, 32'd7, 32'd0);
      wait_done(0);

      // SMULL then UMULL, same operands
      issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 4'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0);
      wait_done(0);
      issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0);
      wait_done(0);

      // UMLAL of zeros, then SMLAL accepted in the done cycle
      issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 4'd7, 32'd0, 32'd0, 32'd0, 32'd0);
      wait_done(0);
      issue(1'b1, 1'b1, 1'b1, 1'b1, 4'd8, 4'd9, 32'h8000_0001, 32'hFFFF_F000,
            32'h1234_5678, 32'hFFFF_FFFF);
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_done(0);

      // start pulses while busy are ignored
      issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd12, 4'd13, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         Rm_data = $urandom; Rs_data = $urandom; rd_in = 4'd15; long_op = 1'b0;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         chk("busy_hold", 64'(busy), 64'd1);
      end
      wait_done(3);
      watch_quiet("extra_done", 8);

      // flush on the second ITER cycle
      issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 4'd0, 32'h1234, 32'h0100_0000, 32'd0, 32'd0);
      void'(sb.pop_back());
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      watch_quiet("flush_no_write", 8);
      chk("flush_hold", 64'(Rd_data), 64'd2);

      // flush with start while idle drops the start
      Rm_data = 32'd9; Rs_data = 32'd9;
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", 64'(busy), 64'd0);
      watch_quiet("flush_start_no_write", 4);

      // reset in the middle of ITER
      issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 4'd15, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_data", {RdHi_data, Rd_data}, 64'd0);
      chk("mid_rst_misc", 64'({done, regWrite, regHiWrite, flags_we, flag_n, flag_z, Rd, RdHi}), 64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      watch_quiet("post_rst_quiet", 6);
      issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd11, 4'd0, 32'd2, 32'd2, 32'd0, 32'd0);
      wait_done(0);

      // mixed ops across all termination depths
      for (int i = 0; i < 8; i++) begin
         r = $urandom;
         case (i % 5)
            0:       rs = r >> 24;
            1:       rs = r >> 16;
            2:       rs = r | 32'hFFFF_FF00;
            3:       rs = r | 32'hFFFF_0000;
            default: rs = r;
         endcase
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               $urandom, rs, $urandom, $urandom);
         wait_done(0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arm_multiplier.md
Name: arm_multiplier

Overview:
- Multi-cycle ARM7TDMI multiply unit for MUL, MLA, UMULL, SMULL, UMLAL and SMLAL.
- Sits directly downstream of the banked register file. It takes the Rm, Rs and Rn read data as operands.
- It writes back through the register file's Rd/RdHi write ports and its regWrite/regHiWrite strobes.
- Latency follows the ARM7 early-termination rule, so the pipeline stall count matches hardware timing.

Parameters:
EARLY_TERM, 1, 1 = iteration count depends on Rs magnitude; 0 = always 4 iterations.

Ports:
clk  input  1  core clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on posedge only when busy=0
accumulate  input  1  add accumulator (MLA/xMLAL)
long_op  input  1  64-bit result (xMULL/xMLAL)
signed_op  input  1  signed operands (SMULL/SMLAL); ignored when long_op=0
set_flags  input  1  S bit
rd_in  input  4  destination (RdLo for long ops)
rdhi_in  input  4  RdHi index for long ops
Rm_data  input  32  multiplicand
Rs_data  input  32  multiplier
Rn_data  input  32  accumulate value (MLA: Rn; long: RdLo)
acc_hi  input  32  RdHi accumulate value for xMLAL
flush  input  1  synchronous cancel of in-flight op
busy  output  1  op in flight; upstream holds the pipeline while high
done  output  1  one-cycle completion pulse
Rd  output  4  registered rd_in
RdHi  output  4  registered rdhi_in
Rd_data  output  32  result[31:0]
RdHi_data  output  32  result[63:32]
regWrite  output  1  equals done
regHiWrite  output  1  done & long
flag_n  output  1  N result
flag_z  output  1  Z result
flags_we  output  1  done & set_flags

Behaviour:
- Reset, asynchronous while rst_n=0:
  - State goes to IDLE.
  - All outputs are 0, including busy, done, regWrite, regHiWrite and flags_we.
  - An in-flight operation is discarded with no write.
- Accept: start=1 and busy=0 at a posedge latches the operands, the indices and all control bits. busy=1 from that edge.
  - start while busy=1 is ignored and has no side effect.
- Iteration count m, computed from the latched Rs:
  - m=1 if Rs[31:8] all zero; 2 if Rs[31:16] all zero; 3 if Rs[31:24] all zero; else 4.
  - "All one" also terminates when the op is MUL/MLA (long_op=0), or when signed_op=1.
  - UMULL/UMLAL terminate only on all-zero.
  - EARLY_TERM=0 forces m=4.
- States:
  - IDLE.
  - ITER: m cycles, consuming 8 multiplier bits per cycle.
  - ACC: 1 cycle, only if accumulate.
  - HI: 1 cycle, only if long_op.
  - Then back to IDLE.
- Latency: N = m + accumulate + long_op cycles. done is high for exactly one cycle starting at the Nth posedge after the accept edge.
  - busy drops on that same edge.
  - A new start may be accepted in the cycle done is high (back-to-back ops).
- Arithmetic: the result must be bit-exact. The internal partial-product scheme is free.
  - Short: Rd_data = (Rm*Rs + (accumulate ? Rn : 0)) mod 2^32. RdHi_data = 0.
  - Long unsigned: {RdHi_data, Rd_data} = zero-extended Rm × zero-extended Rs + (accumulate ? {acc_hi, Rn} : 0), mod 2^64.
  - Long signed: same, using sign-extended operands.
- Flags:
  - flag_n = result bit 31 (short) or bit 63 (long).
  - flag_z = 1 iff the 32-bit (short) or 64-bit (long) result is zero.
  - C and V are not produced.
- Output hold: Rd, RdHi, Rd_data, RdHi_data, flag_n and flag_z hold their values after done until the next completion.
- Write strobes: regWrite, regHiWrite and flags_we are high only in the done cycle.
- flush=1 at a posedge while busy: returns to IDLE, busy=0, no done, no write strobes.
  - flush while idle has no effect.
  - flush together with start while idle: flush wins, and the start is dropped.
- Write conflicts: Rd==RdHi on a long op is unchecked (architecturally unpredictable). Both strobes assert and the register file resolves the conflict.
- Modes: none. Banking is resolved by the register file using the mode at write time.

Test Plan:
- MUL Rm=3, Rs=5 -> m=1, done 1 cycle after accept, Rd_data=15, regWrite=1, regHiWrite=0, flag_z=0.
- MLA Rm=0x00010000, Rs=0x00010000, Rn=7, set_flags=1 -> done after 4 cycles, Rd_data=0x00000007, flags_we=1, flag_n=0, flag_z=0.
- SMULL Rm=0xFFFFFFFE, Rs=0xFFFFFFFF -> m=1, done after 2 cycles, Rd_data=2, RdHi_data=0, regHiWrite=1. UMULL with the same operands -> m=4, done after 5 cycles, RdHi_data=0xFFFFFFFD, Rd_data=0x00000002, flag_n=1.
- UMLAL Rm=0, Rs=0, Rn=0, acc_hi=0, set_flags=1 -> done after 3 cycles, result 0, flag_z=1. Second start in the done cycle is accepted, with busy staying high.
- Start pulses during busy -> ignored, single done. flush on the 2nd ITER cycle -> busy=0 next edge, no done/regWrite ever.
- rst_n low mid-ITER -> outputs 0 immediately. After release, a fresh MUL 2×2 completes with Rd_data=4 and no stale write.
